// File: rtl/seg_capture.sv
// Captures a multiplexed 7-segment clock display into six BCD time digits.
// Optional sec_tick output is enabled by defining SEG_CAPTURE_TICK_EN.
module seg_capture (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_data,
    input  logic [7:0] seg_com,
    output logic [3:0] h_ten,
    output logic [3:0] h_one,
    output logic [3:0] m_ten,
    output logic [3:0] m_one,
    output logic [3:0] s_ten,
    output logic [3:0] s_one,
    output logic       frame_valid,
    output logic       err,
    output logic       stale
`ifdef SEG_CAPTURE_TICK_EN
    ,
    output logic       sec_tick
`endif
);

    typedef enum logic [1:0] {SlotBlank, SlotDigit, SlotError} slot_e;

    // Stage 1: raw input registers
    logic [7:0] seg_q;
    logic [7:0] com_q;
    logic       s1_valid_q;

    // Stage 2: frame assembly and committed time
    logic [5:0][3:0] shadow_q, shadow_d;
    logic [5:0][3:0] time_q, time_d;
    logic [5:0]      seen_q, seen_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            fv_q, fv_d;
    logic            err_q, err_d;
    logic            stale_q, stale_d;
    logic            commit;
    logic            range_ok;

    slot_e      slot;
    logic [2:0] slot_idx;
    logic       pat_ok;
    logic [3:0] pat_val;

    // The decimal point carries no time information.
    logic unused_dp;
    assign unused_dp = seg_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            com_q      <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            seg_q      <= seg_data;
            com_q      <= seg_com;
            s1_valid_q <= 1'b1;
        end
    end

    // The cleared stage-1 contents right after reset are treated as a blank slot.
    always_comb begin
        slot     = SlotError;
        slot_idx = 3'd0;
        if (!s1_valid_q) begin
            slot = SlotBlank;
        end else begin
            case (com_q)
                8'b0111_1111: begin slot = SlotDigit; slot_idx = 3'd0; end
                8'b1011_1111: begin slot = SlotDigit; slot_idx = 3'd1; end
                8'b1101_1111: begin slot = SlotDigit; slot_idx = 3'd2; end
                8'b1110_1111: begin slot = SlotDigit; slot_idx = 3'd3; end
                8'b1111_0111: begin slot = SlotDigit; slot_idx = 3'd4; end
                8'b1111_1011: begin slot = SlotDigit; slot_idx = 3'd5; end
                8'b1111_1101,
                8'b1111_1110,
                8'b1111_1111: slot = SlotBlank;
                default:      slot = SlotError;
            endcase
        end
    end

    always_comb begin
        pat_ok  = 1'b1;
        pat_val = 4'd0;
        case (seg_q[7:1])
            7'b1111110: pat_val = 4'd0;
            7'b0110000: pat_val = 4'd1;
            7'b1101101: pat_val = 4'd2;
            7'b1111001: pat_val = 4'd3;
            7'b0110011: pat_val = 4'd4;
            7'b1011011: pat_val = 4'd5;
            7'b1011111: pat_val = 4'd6;
            7'b1110000: pat_val = 4'd7;
            7'b1111111: pat_val = 4'd8;
            7'b1111011: pat_val = 4'd9;
            default:    pat_ok  = 1'b0;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        time_d   = time_q;
        cnt_d    = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        stale_d  = stale_q;
        commit   = 1'b0;
        range_ok = 1'b0;

        if (slot == SlotError) begin
            err_d  = 1'b1;
            seen_d = '0;
        end else if (slot == SlotDigit) begin
            cnt_d = 5'd0;
            if (pat_ok) begin
                shadow_d[slot_idx] = pat_val;
                seen_d[slot_idx]   = 1'b1;
            end else begin
                err_d            = 1'b1;
                seen_d[slot_idx] = 1'b0;
            end

            // Slot 5 closes the frame; the fresh s_one is taken from shadow_d.
            if (slot_idx == 3'd5) begin
                range_ok = ((shadow_d[0] < 4'd2) ||
                            (shadow_d[0] == 4'd2 && shadow_d[1] <= 4'd3)) &&
                           (shadow_d[2] <= 4'd5) && (shadow_d[4] <= 4'd5);
                if (pat_ok && (&seen_q[4:0])) begin
                    if (range_ok) begin
                        commit = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                seen_d = '0;
            end
        end

        if (cnt_d == 5'd16) begin
            stale_d = 1'b1;
        end

        if (commit) begin
            time_d  = shadow_d;
            fv_d    = 1'b1;
            stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            time_q   <= '0;
            seen_q   <= '0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            time_q   <= time_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
        end
    end

`ifdef SEG_CAPTURE_TICK_EN
    logic tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= commit && (shadow_d[5] != time_q[5]);
        end
    end

    assign sec_tick = tick_q;
`endif

    assign h_ten       = time_q[0];
    assign h_one       = time_q[1];
    assign m_ten       = time_q[2];
    assign m_one       = time_q[3];
    assign s_ten       = time_q[4];
    assign s_one       = time_q[5];
    assign frame_valid = fv_q;
    assign err         = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed table-driven bench for seg_capture, plus hand sequences for reset and sec_tick.
module tb_seg_capture;

    localparam logic [7:0] C0 = 8'h7F;
    localparam logic [7:0] C1 = 8'hBF;
    localparam logic [7:0] C2 = 8'hDF;
    localparam logic [7:0] C3 = 8'hEF;
    localparam logic [7:0] C4 = 8'hF7;
    localparam logic [7:0] C5 = 8'hFB;
    localparam logic [7:0] B6 = 8'hFD;
    localparam logic [7:0] B7 = 8'hFE;
    localparam logic [7:0] BL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_data;
    logic [7:0] seg_com;
    logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
    logic       frame_valid;
    logic       err;
    logic       stale;
    logic       tick;
    logic [23:0] tm;

    int passed = 0;
    int total  = 0;
    int fv_cnt = 0;
    int tick_cnt = 0;

    seg_capture dut (
        .clk         (clk),
        .rst         (rst),
        .seg_data    (seg_data),
        .seg_com     (seg_com),
        .h_ten       (h_ten),
        .h_one       (h_one),
        .m_ten       (m_ten),
        .m_one       (m_one),
        .s_ten       (s_ten),
        .s_one       (s_one),
        .frame_valid (frame_valid),
        .err         (err),
        .stale       (stale)
`ifdef SEG_CAPTURE_TICK_EN
        ,
        .sec_tick    (tick)
`endif
    );

`ifndef SEG_CAPTURE_TICK_EN
    assign tick = 1'b0;
`endif

    assign tm = {h_ten, h_one, m_ten, m_one, s_ten, s_one};

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  com;
        logic [7:0]  data;
        logic        fv;
        logic        er;
        logic        st;
        logic [23:0] tm;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] seg(input int d);
        logic [6:0] p;
        case (d)
            0:       p = 7'b1111110;
            1:       p = 7'b0110000;
            2:       p = 7'b1101101;
            3:       p = 7'b1111001;
            4:       p = 7'b0110011;
            5:       p = 7'b1011011;
            6:       p = 7'b1011111;
            7:       p = 7'b1110000;
            8:       p = 7'b1111111;
            default: p = 7'b1111011;
        endcase
        return {p, 1'b0};
    endfunction

    task automatic add(input logic [7:0] com, input logic [7:0] data, input logic fv,
                       input logic er, input logic st, input logic [23:0] t);
        vec_t v;
        v.com  = com;
        v.data = data;
        v.fv   = fv;
        v.er   = er;
        v.st   = st;
        v.tm   = t;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] com, input logic [7:0] data);
        @(negedge clk);
        rst      = r;
        seg_com  = com;
        seg_data = data;
        @(posedge clk);
        #1;
        if (frame_valid) fv_cnt++;
        if (tick) tick_cnt++;
    endtask

    task automatic frame(input int d0, input int d1, input int d2, input int d3,
                         input int d4, input int d5);
        step(1'b0, C0, seg(d0));
        step(1'b0, C1, seg(d1));
        step(1'b0, C2, seg(d2));
        step(1'b0, C3, seg(d3));
        step(1'b0, C4, seg(d4));
        step(1'b0, C5, seg(d5));
    endtask

    initial begin
        // Row r is driven before edge r and checked just after it; stage 2 acts on row r-1.
        add(C0, seg(1), 0, 0, 0, 24'h000000);
        add(C1, seg(2), 0, 0, 0, 24'h000000);
        add(C2, seg(3), 0, 0, 0, 24'h000000);
        add(C3, seg(4), 0, 0, 0, 24'h000000);
        add(C4, seg(5), 0, 0, 0, 24'h000000);
        add(C5, seg(6), 0, 0, 0, 24'h000000);
        add(B6, 8'h00,  1, 0, 0, 24'h123456);
        add(B7, 8'h00,  0, 0, 0, 24'h123456);
        // unlisted pattern in slot 4 breaks the frame
        add(C0, seg(1), 0, 0, 0, 24'h123456);
        add(C1, seg(2), 0, 0, 0, 24'h123456);
        add(C2, seg(3), 0, 0, 0, 24'h123456);
        add(C3, seg(4), 0, 0, 0, 24'h123456);
        add(C4, 8'h02,  0, 0, 0, 24'h123456);
        add(C5, seg(6), 0, 1, 0, 24'h123456);
        add(BL, 8'h00,  0, 0, 0, 24'h123456);
        add(BL, 8'h00,  0, 0, 0, 24'h123456);
        // 25:00:00 fails the range check
        add(C0, seg(2), 0, 0, 0, 24'h123456);
        add(C1, seg(5), 0, 0, 0, 24'h123456);
        add(C2, seg(0), 0, 0, 0, 24'h123456);
        add(C3, seg(0), 0, 0, 0, 24'h123456);
        add(C4, seg(0), 0, 0, 0, 24'h123456);
        add(C5, seg(0), 0, 0, 0, 24'h123456);
        add(BL, 8'h00,  0, 1, 0, 24'h123456);
        add(BL, 8'h00,  0, 0, 0, 24'h123456);
        // common error after slots 0..4 wipes them; then 00:00:01 with dp set
        add(C0, seg(0), 0, 0, 0, 24'h123456);
        add(C1, seg(0), 0, 0, 0, 24'h123456);
        add(C2, seg(0), 0, 0, 0, 24'h123456);
        add(C3, seg(0), 0, 0, 0, 24'h123456);
        add(C4, seg(0), 0, 0, 0, 24'h123456);
        add(8'h3F, seg(1), 0, 0, 0, 24'h123456);
        add(C5, seg(1), 0, 1, 0, 24'h123456);
        add(C0, seg(0) | 8'h01, 0, 0, 0, 24'h123456);
        add(C1, seg(0) | 8'h01, 0, 0, 0, 24'h123456);
        add(C2, seg(0) | 8'h01, 0, 0, 0, 24'h123456);
        add(C3, seg(0) | 8'h01, 0, 0, 0, 24'h123456);
        add(C4, seg(0) | 8'h01, 0, 0, 0, 24'h123456);
        add(C5, seg(1) | 8'h01, 0, 0, 0, 24'h123456);
        // 20 blank cycles: stale rises on the 16th, falls with the next commit
        for (int i = 0; i < 20; i++) begin
            add(BL, 8'h00, (i == 0), 1'b0, (i >= 16), 24'h000001);
        end
        add(C0, seg(0), 0, 0, 1, 24'h000001);
        add(C1, seg(0), 0, 0, 1, 24'h000001);
        add(C2, seg(0), 0, 0, 1, 24'h000001);
        add(C3, seg(0), 0, 0, 1, 24'h000001);
        add(C4, seg(0), 0, 0, 1, 24'h000001);
        add(C5, seg(2), 0, 0, 1, 24'h000001);
        add(BL, 8'h00,  1, 0, 0, 24'h000002);
        add(BL, 8'h00,  0, 0, 0, 24'h000002);

        rst      = 1'b1;
        seg_com  = C0;
        seg_data = seg(8);
        repeat (2) @(posedge clk);
        #1;
        check("reset time", 32'(tm), 32'h0);
        check("reset fv", 32'(frame_valid), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset stale", 32'(stale), 32'h0);
        check("reset tick", 32'(tick), 32'h0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst      = 1'b0;
            seg_com  = tbl[i].com;
            seg_data = tbl[i].data;
            @(posedge clk);
            #1;
            check($sformatf("row%0d fv", i), 32'(frame_valid), 32'(tbl[i].fv));
            check($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].er));
            check($sformatf("row%0d stale", i), 32'(stale), 32'(tbl[i].st));
            check($sformatf("row%0d time", i), 32'(tm), 32'(tbl[i].tm));
`ifdef SEG_CAPTURE_TICK_EN
            check($sformatf("row%0d tick", i), 32'(tick), 32'(tbl[i].fv));
`endif
        end

        // reset after slot 3 discards the partial frame
        step(1'b0, C0, seg(2));
        step(1'b0, C1, seg(3));
        step(1'b0, C2, seg(5));
        step(1'b0, C3, seg(9));
        step(1'b1, C4, seg(5));
        check("midreset time", 32'(tm), 32'h0);
        step(1'b1, C4, seg(5));
        check("midreset time2", 32'(tm), 32'h0);
        check("midreset flags", 32'({frame_valid, err, stale}), 32'h0);
        fv_cnt = 0;
        step(1'b0, C4, seg(5));
        step(1'b0, C5, seg(9));
        step(1'b0, BL, 8'h00);
        step(1'b0, BL, 8'h00);
        check("partial after reset commits", 32'(fv_cnt), 32'h0);

        fv_cnt   = 0;
        tick_cnt = 0;
        frame(2, 3, 5, 9, 5, 9);
        for (int i = 0; i < 4; i++) step(1'b0, BL, 8'h00);
        check("235959 commits", 32'(fv_cnt), 32'h1);
        check("235959 time", 32'(tm), 32'h235959);
`ifdef SEG_CAPTURE_TICK_EN
        check("235959 ticks", 32'(tick_cnt), 32'h1);
`endif

        // same s_one again: commit without tick
        fv_cnt   = 0;
        tick_cnt = 0;
        frame(2, 3, 5, 9, 5, 9);
        for (int i = 0; i < 4; i++) step(1'b0, BL, 8'h00);
        check("repeat commits", 32'(fv_cnt), 32'h1);
        check("repeat time", 32'(tm), 32'h235959);
        check("repeat stale", 32'(stale), 32'h0);
`ifdef SEG_CAPTURE_TICK_EN
        check("repeat ticks", 32'(tick_cnt), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
